// File: rtl/id_decode_pipe.sv
// Registered RV32I decode stage with valid/ready on both sides.
// A main/skid entry pair keeps full rate under back-pressure.
module id_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_opclass,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [3:0] {
    C_LUI   = 4'd0,
    C_AUIPC = 4'd1,
    C_JAL   = 4'd2,
    C_JALR  = 4'd3,
    C_BR    = 4'd4,
    C_LOAD  = 4'd5,
    C_ST    = 4'd6,
    C_OPIMM = 4'd7,
    C_OP    = 4'd8,
    C_MISC  = 4'd9,
    C_SYS   = 4'd10,
    C_ILL   = 4'd15
  } opclass_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic            f7b5;
    logic [XLEN-1:0] imm;
    logic            we;
    logic            ill;
  } entry_t;

  entry_t           r_main;
  entry_t           r_skid;
  logic             r_main_v;
  logic             r_skid_v;
  logic [CNT_W-1:0] r_cnt;

  entry_t           w_dec;
  opclass_e         w_cls;
  logic             w_bad;
  logic [31:0]      w_imm32;
  logic             w_acc;
  logic             w_hand;

  assign w_bad = (in_instr[1:0] != 2'b11)
               || (in_instr == 32'h0)
               || (in_instr == 32'hFFFF_FFFF);

  always_comb begin
    w_cls = C_ILL;
    case (in_instr[6:0])
      7'b0110111: w_cls = C_LUI;
      7'b0010111: w_cls = C_AUIPC;
      7'b1101111: w_cls = C_JAL;
      7'b1100111: w_cls = C_JALR;
      7'b1100011: w_cls = C_BR;
      7'b0000011: w_cls = C_LOAD;
      7'b0100011: w_cls = C_ST;
      7'b0010011: w_cls = C_OPIMM;
      7'b0110011: w_cls = C_OP;
      7'b0001111: w_cls = C_MISC;
      7'b1110011: w_cls = C_SYS;
      default:    w_cls = C_ILL;
    endcase
    if (w_bad) w_cls = C_ILL;
  end

  always_comb begin
    w_imm32 = '0;
    unique case (w_cls)
      C_LUI, C_AUIPC:
        w_imm32 = {in_instr[31:12], 12'b0};
      C_JAL:
        w_imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      C_BR:
        w_imm32 = {{20{in_instr[31]}}, in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      C_ST:
        w_imm32 = {{20{in_instr[31]}},
                   in_instr[31:25], in_instr[11:7]};
      C_JALR, C_LOAD, C_OPIMM, C_MISC, C_SYS:
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      default:
        w_imm32 = '0;
    endcase
  end

  always_comb begin
    w_dec      = '0;
    w_dec.pc   = in_pc;
    w_dec.cls  = w_cls;
    w_dec.rd   = in_instr[11:7];
    w_dec.rs1  = in_instr[19:15];
    w_dec.rs2  = in_instr[24:20];
    w_dec.f3   = in_instr[14:12];
    w_dec.f7b5 = in_instr[30];
    w_dec.imm  = XLEN'($signed(w_imm32));
    w_dec.ill  = (w_cls == C_ILL);
    if (w_cls inside {C_BR, C_ST, C_ILL})
      w_dec.rd = '0;
    if (w_cls inside {C_LUI, C_AUIPC, C_JAL})
      w_dec.rs1 = '0;
    if (!(w_cls inside {C_BR, C_ST, C_OP}))
      w_dec.rs2 = '0;
    w_dec.we = (w_cls inside {C_LUI, C_AUIPC, C_JAL, C_JALR,
                              C_LOAD, C_OPIMM, C_OP})
             && (w_dec.rd != 5'd0);
  end

  assign w_acc  = in_valid && in_ready && !flush;
  assign w_hand = r_main_v && out_ready && !flush;

  // in_ready depends only on the skid flag, so out_ready never
  // reaches it combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main   <= '0;
      r_skid   <= '0;
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || w_hand) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= w_acc;
        if (w_acc) r_main <= w_dec;
      end
    end else if (w_acc) begin
      r_skid   <= w_dec;
      r_skid_v <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_hand && r_main.ill && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign in_ready     = !r_skid_v;
  assign out_valid    = r_main_v;
  assign out_pc       = r_main.pc;
  assign out_opclass  = r_main.cls;
  assign out_rd       = r_main.rd;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_funct3   = r_main.f3;
  assign out_funct7b5 = r_main.f7b5;
  assign out_imm      = r_main.imm;
  assign out_we       = r_main.we;
  assign out_illegal  = r_main.ill;
  assign illegal_cnt  = r_cnt;

endmodule
